// File: rtl/ez8_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ez8_isa_pkg
//  Brief    : ez8 instruction-word field positions and opcode constants,
//             shared by the decode stage and the ALU.
//  Revision : 1.0  initial release
// ============================================================================
package ez8_isa_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int OPC_MSB     = 15;
  localparam int SEL_MSB     = 11;
  localparam int DIR_BIT     = 8;
  localparam int OPERAND_MSB = 7;

  localparam int OPC_WIDTH     = 4;
  localparam int SEL_WIDTH     = 3;
  localparam int OPERAND_WIDTH = 8;

  localparam logic [OPC_WIDTH-1:0] GET_PUT = 4'b0000;
  localparam logic [OPC_WIDTH-1:0] SET     = 4'b0100;
  localparam logic [OPC_WIDTH-1:0] SKBC    = 4'b1100;
  localparam logic [OPC_WIDTH-1:0] RET     = 4'b1101;
  localparam logic [OPC_WIDTH-1:0] CLR_COM = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode
//  Brief    : ez8 decode/issue stage: single-slot field split with skip
//             squashing, flush and interrupt-entry control.
//  Revision : 1.0  initial release
// ============================================================================
module instr_decode
  import ez8_isa_pkg::*;
#(
  parameter int PC_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPC_WIDTH-1:0]     opcode,
  output logic [SEL_WIDTH-1:0]     selector,
  output logic                     direction,
  output logic [OPERAND_WIDTH-1:0] operand,
  output logic [PC_WIDTH-1:0]      out_pc,
  input  logic                     ex_done,
  input  logic                     alu_skip,
  input  logic                     alu_retint,
  input  logic                     flush,
  input  logic                     irq,
  output logic                     irq_take,
  output logic                     int_en
);

  logic                     r_out_valid;
  logic                     r_skip_pending;
  logic                     r_int_en;
  logic                     r_retint_defer;
  logic [OPC_WIDTH-1:0]     r_opcode;
  logic [SEL_WIDTH-1:0]     r_selector;
  logic                     r_direction;
  logic [OPERAND_WIDTH-1:0] r_operand;
  logic [PC_WIDTH-1:0]      r_pc;

  logic w_slot_free;
  logic w_take_irq;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_skip;
  logic w_retint;

  assign w_slot_free = !r_out_valid || out_ready;
  // Gated by reset so no interrupt entry is reported while held in reset.
  assign w_take_irq  = irq && r_int_en && !flush && !r_skip_pending && w_slot_free && !reset;
  assign w_in_ready  = w_slot_free && !flush && !w_take_irq;
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_skip      = ex_done && alu_skip;
  assign w_retint    = ex_done && alu_retint;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_skip_pending <= 1'b0;
      r_opcode       <= '0;
      r_selector     <= '0;
      r_direction    <= 1'b0;
      r_operand      <= '0;
      r_pc           <= '0;
    end else if (flush) begin
      r_out_valid    <= 1'b0;
      r_skip_pending <= 1'b0;
    end else if (w_skip && r_out_valid) begin
      // Execute holds out_ready low with ex_done, so the slot is the successor.
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      if (r_skip_pending || w_skip) begin
        r_out_valid    <= 1'b0;
        r_skip_pending <= r_skip_pending && w_skip;
      end else begin
        r_out_valid <= 1'b1;
        r_opcode    <= in_instr[OPC_MSB -: OPC_WIDTH];
        r_selector  <= in_instr[SEL_MSB -: SEL_WIDTH];
        r_direction <= in_instr[DIR_BIT];
        r_operand   <= in_instr[OPERAND_MSB:0];
        r_pc        <= in_pc;
      end
    end else begin
      if (w_skip) begin
        r_skip_pending <= 1'b1;
      end
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // A retint coinciding with interrupt entry is remembered and applied next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_en       <= 1'b1;
      r_retint_defer <= 1'b0;
    end else if (w_take_irq) begin
      r_int_en       <= 1'b0;
      r_retint_defer <= w_retint;
    end else if (w_retint || r_retint_defer) begin
      r_int_en       <= 1'b1;
      r_retint_defer <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign opcode    = r_opcode;
  assign selector  = r_selector;
  assign direction = r_direction;
  assign operand   = r_operand;
  assign out_pc    = r_pc;
  assign irq_take  = w_take_irq;
  assign int_en    = r_int_en;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_decode
//  Brief    : self-checking bench for instr_decode against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_decode;
  import ez8_isa_pkg::*;

  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_instr;
  logic [PW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    opcode;
  logic [2:0]    selector;
  logic          direction;
  logic [7:0]    operand;
  logic [PW-1:0] out_pc;
  logic          ex_done;
  logic          alu_skip;
  logic          alu_retint;
  logic          flush;
  logic          irq;
  logic          irq_take;
  logic          int_en;

  instr_decode #(.PC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .selector(selector), .direction(direction), .operand(operand),
    .out_pc(out_pc),
    .ex_done(ex_done), .alu_skip(alu_skip), .alu_retint(alu_retint),
    .flush(flush), .irq(irq), .irq_take(irq_take), .int_en(int_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: one slot, a count of owed drops, interrupt enable.
  bit            m_valid;
  logic [15:0]   m_instr;
  logic [PW-1:0] m_pc;
  int            m_owed;
  bit            m_ien;
  bit            m_defer;

  bit            last_fire;
  bit            last_take;
  logic [PW-1:0] issued[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_instr = '0; m_pc = '0; m_owed = 0; m_ien = 1; m_defer = 0;
  endtask

  task automatic check_regs();
    chk("out_valid", out_valid, m_valid);
    chk("opcode",    opcode,    m_instr[15:12]);
    chk("selector",  selector,  m_instr[11:9]);
    chk("direction", direction, m_instr[8]);
    chk("operand",   operand,   m_instr[7:0]);
    chk("out_pc",    out_pc,    m_pc);
    chk("int_en",    int_en,    m_ien);
  endtask

  task automatic idle();
    in_valid = 0; in_instr = '0; in_pc = '0; out_ready = 1;
    ex_done = 0; alu_skip = 0; alu_retint = 0; flush = 0; irq = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit exp_take, exp_rdy, fire, retint;
    int owed;
    #1;
    exp_take = irq && m_ien && !flush && (m_owed == 0) && (!m_valid || out_ready);
    exp_rdy  = (!m_valid || out_ready) && !flush && !exp_take;
    chk("irq_take", irq_take, exp_take);
    chk("in_ready", in_ready, exp_rdy);
    fire      = in_valid && exp_rdy;
    last_fire = fire;
    last_take = irq_take;
    if (out_valid && out_ready) issued.push_back(out_pc);
    retint = ex_done && alu_retint;

    if (exp_take) begin
      m_ien = 0; m_defer = retint;
    end else if (retint || m_defer) begin
      m_ien = 1; m_defer = 0;
    end

    if (flush) begin
      m_valid = 0; m_owed = 0;
    end else begin
      owed = m_owed + ((ex_done && alu_skip) ? 1 : 0);
      if (m_valid && ex_done && alu_skip) begin
        m_valid = 0; owed--;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (fire) begin
        if (owed > 0) owed--;
        else begin m_valid = 1; m_instr = in_instr; m_pc = in_pc; end
      end
      m_owed = (owed > 0) ? 1 : 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  // Offer consecutive pcs until n of them have been accepted.
  task automatic feed(input logic [PW-1:0] base, input int n);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 50) begin
      in_valid = 1; in_pc = base + PW'(idx); in_instr = 16'($urandom);
      cycle();
      if (last_fire) idx++;
      guard++;
    end
    if (idx < n) chk("feed_timeout", idx, n);
    in_valid = 0;
  endtask

  task automatic drain();
    idle();
    cycle();
    cycle();
    issued.delete();
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_int_en", int_en, 1);
    chk("rst_irq_take", irq_take, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    check_regs();

    // Basic issue
    in_valid = 1; in_instr = 16'hD301; in_pc = 12'h040;
    cycle();
    chk("basic_opcode", opcode, 4'hD);
    chk("basic_selector", selector, 3'b001);
    chk("basic_direction", direction, 1);
    chk("basic_operand", operand, 8'h01);
    chk("basic_pc", out_pc, 12'h040);
    drain();
    feed(12'h050, 4);
    idle(); cycle();
    chk("b2b_count", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("b2b_pc", issued[i], 12'h050 + i);

    // Backpressure
    drain();
    out_ready = 0;
    feed(12'h060, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = 12'h061; in_instr = 16'h1234; out_ready = 0;
      cycle();
      chk("bp_in_ready", last_fire, 0);
      chk("bp_pc_stable", out_pc, 12'h060);
    end
    out_ready = 1;
    feed(12'h061, 2);
    idle(); cycle();
    chk("bp_count", issued.size(), 3);
    for (int i = 0; i < 3 && i < issued.size(); i++) chk("bp_pc", issued[i], 12'h060 + i);

    // Skip with full slot
    drain();
    out_ready = 0;
    feed(12'h041, 1);
    ex_done = 1; alu_skip = 1; out_ready = 0;
    cycle();
    chk("skipfull_valid", out_valid, 0);
    idle();
    feed(12'h042, 1);
    idle(); cycle();
    chk("skipfull_count", issued.size(), 1);
    if (issued.size() > 0) chk("skipfull_pc", issued[0], 12'h042);

    // Skip with empty slot
    drain();
    ex_done = 1; alu_skip = 1; out_ready = 0;
    cycle();
    idle();
    feed(12'h041, 2);
    idle(); cycle();
    chk("skipempty_count", issued.size(), 1);
    if (issued.size() > 0) chk("skipempty_pc", issued[0], 12'h042);

    // Flush cancels a simultaneous skip
    drain();
    ex_done = 1; alu_skip = 1; out_ready = 0; flush = 1;
    cycle();
    idle();
    feed(12'h041, 2);
    idle(); cycle();
    chk("skipflush_count", issued.size(), 2);
    if (issued.size() > 1) chk("skipflush_pc", issued[0], 12'h041);

    // Interrupt entry and return
    drain();
    irq = 1; in_valid = 1; in_pc = 12'h070;
    cycle();
    chk("irq_pulse", last_take, 1);
    chk("irq_no_accept", last_fire, 0);
    chk("irq_int_en", int_en, 0);
    in_valid = 0;
    cycle();
    chk("irq_no_second", last_take, 0);
    ex_done = 1; alu_retint = 1; out_ready = 0;
    cycle();
    chk("retint_int_en", int_en, 1);
    ex_done = 0; alu_retint = 0; out_ready = 1;
    cycle();
    chk("irq_retake", last_take, 1);

    // Reset mid-operation
    drain();
    out_ready = 0;
    feed(12'h0A5, 1);
    chk("pre_rst_valid", out_valid, 1);
    #2;
    reset = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_int_en", int_en, 1);
    chk("midrst_opcode", opcode, 0);
    chk("midrst_pc", out_pc, 0);
    model_reset();
    idle();
    @(negedge clk);
    reset = 0;

    // Randomized traffic honouring the execute contract
    begin
      logic [PW-1:0] pc_next = 12'h100;
      for (int c = 0; c < 3000; c++) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        in_pc      = pc_next;
        in_instr   = 16'($urandom);
        ex_done    = ($urandom_range(0, 4) == 0);
        alu_skip   = ex_done && ($urandom_range(0, 2) == 0);
        alu_retint = ex_done && ($urandom_range(0, 3) == 0);
        out_ready  = !ex_done && ($urandom_range(0, 3) != 0);
        flush      = ($urandom_range(0, 15) == 0);
        irq        = ($urandom_range(0, 5) == 0);
        cycle();
        if (last_fire) pc_next = pc_next + 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
